// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide engine for MULT (3'b111) and DIV (3'b101).
// MULT: {hi,lo} = op_a * op_b. DIV: lo = quotient, hi = remainder.
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset
//   ALU_aluOp[2:0]   - operation code; only MULT/DIV are accepted
//   start            - request, accepted in IDLE or DONE
//   op_a, op_b       - multiplicand/dividend, multiplier/divisor
//   busy             - high while iterating or fixing up the result
//   done             - one-cycle pulse, hi/lo/div_zero valid
//   hi, lo           - result registers, held between completions
//   div_zero         - last DIV had a zero divisor
// Build option: define MULDIV_SIGNED_EN for two's-complement operands;
// otherwise operands are unsigned. Latency is identical in both builds.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ALU_aluOp,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam logic [2:0]       OP_MULT   = 3'b111;
    localparam logic [2:0]       OP_DIV    = 3'b101;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;     // MULT: product/multiplier; DIV: quotient in low half
    logic [WIDTH-1:0]   rem_q, rem_d;     // DIV partial remainder
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;   // |op_b|: multiplicand or divisor
    logic               is_div_q, is_div_d;
    logic               dz_q, dz_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_zero_q, div_zero_d;

    logic               is_div_op, accept, b_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               sgn_ab, sgn_a;

    always_comb begin
        is_div_op = (ALU_aluOp == OP_DIV);
        b_zero    = (op_b == '0);
        accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                    ((ALU_aluOp == OP_MULT) || is_div_op);
`ifdef MULDIV_SIGNED_EN
        mag_a  = op_a[WIDTH-1] ? -op_a : op_a;
        mag_b  = op_b[WIDTH-1] ? -op_b : op_b;
        sgn_ab = op_a[WIDTH-1] ^ op_b[WIDTH-1];
        sgn_a  = op_a[WIDTH-1];
`else
        mag_a  = op_a;
        mag_b  = op_b;
        sgn_ab = 1'b0;
        sgn_a  = 1'b0;
`endif
    end

    // One iteration step. The restoring trial value is WIDTH+1 bits; since the
    // remainder stays below the divisor, the difference always fits in WIDTH bits.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, dvsr_q});
        div_diff  = div_shift[WIDTH-1:0] - dvsr_q;
        prod_fix  = neg_lo_q ? -acc_q : acc_q;
        quo_fix   = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_hi_q ? -rem_q : rem_q;
    end

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            dvsr_q     <= '0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            dvsr_q     <= dvsr_d;
            is_div_q   <= is_div_d;
            dz_q       <= dz_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Next state. A zero divisor skips the iterations and only spends the
    // FIX cycle, so done appears one edge after acceptance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept)
                    state_d = (is_div_op && b_zero) ? S_FIX : S_ITER;
                else if (state_q == S_DONE)
                    state_d = S_IDLE;
            end
            S_ITER:  if (cnt_q == LAST_STEP) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        dvsr_d     = dvsr_q;
        is_div_d   = is_div_q;
        dz_d       = dz_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        if (accept) begin
            cnt_d              = '0;
            rem_d              = '0;
            dvsr_d             = mag_b;
            is_div_d           = is_div_op;
            dz_d               = is_div_op && b_zero;
            acc_d              = '0;
            acc_d[WIDTH-1:0]   = (is_div_op && b_zero) ? op_a : mag_a;
            neg_lo_d           = sgn_ab;
            neg_hi_d           = is_div_op ? sgn_a : sgn_ab;
            div_zero_d         = 1'b0;
        end else if (state_q == S_ITER) begin
            cnt_d = cnt_q + 1'b1;
            if (is_div_q) begin
                acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], div_ge};
                rem_d            = div_ge ? div_diff : div_shift[WIDTH-1:0];
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end else if (state_q == S_FIX) begin
            if (dz_q) begin
                hi_d       = acc_q[WIDTH-1:0];
                lo_d       = '1;
                div_zero_d = 1'b1;
            end else if (is_div_q) begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end else begin
                hi_d = prod_fix[2*WIDTH-1:WIDTH];
                lo_d = prod_fix[WIDTH-1:0];
            end
        end
    end

    // Outputs
    always_comb begin
        busy     = (state_q == S_ITER) || (state_q == S_FIX);
        done     = (state_q == S_DONE);
        hi       = hi_q;
        lo       = lo_q;
        div_zero = div_zero_q;
    end

endmodule
